md_sched: RTL and testbench

- Multiply/divide scheduler for the E stage of the five-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E, runs the multi-cycle operation on latched operands, and holds the HI/LO architectural registers.
- Raises the global stall term that freezes D/PC and flushes E whenever the D-stage instruction needs the unit while it is occupied.
- Its stall output is OR-ed with the existing hazard stall.

---
 rtl/md_sched.sv | 140 ++++++++++++++
 tb/tb_md_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the E stage.
// Latches operands when a mult/multu/div/divu enters E, counts a fixed number
// of busy cycles, then commits the result to the HI/LO architectural registers.
// mthi/mtlo write HI/LO directly in a single cycle. MDStall asks the pipeline to
// hold a D-stage md/mfhi/mflo instruction while the unit is starting or running.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MDUse,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        MDStall
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic { S_IDLE = 1'b0, S_RUN = 1'b1 } state_t;

  state_t      state_q;
  logic        busy_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic        is_long_op;
  logic        start;
  logic [63:0] res;
  logic        div_by_zero;

  // Full {HI,LO} result of a long op; operands are widened to 64 bits so that
  // the signed INT_MIN / -1 case wraps instead of overflowing.
  function automatic logic [63:0] md_result(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    md_result = 64'd0;
    case (op)
      OP_MULT:  md_result = sa * sb;
      OP_MULTU: md_result = ua * ub;
      OP_DIV: begin
        if (b != 32'd0) begin
          sq = sa / sb;
          sr = sa % sb;
          md_result = {sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: begin
        if (b != 32'd0) begin
          uq = ua / ub;
          ur = ua % ub;
          md_result = {ur[31:0], uq[31:0]};
        end
      end
      default: md_result = 64'd0;
    endcase
  endfunction

  assign is_long_op  = (E_MDOp >= OP_MULT) && (E_MDOp <= OP_DIVU);
  assign start       = (state_q == S_IDLE) && is_long_op;
  assign div_by_zero = ((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == 32'd0);

  // Result of the latched operation, consumed on the completing edge.
  always_comb begin
    res = md_result(op_q, a_q, b_q);
  end

  // Operand latch: loaded only when a long op starts, left alone while running.
  always_ff @(posedge clk) begin
    if (start) begin
      a_q  <= E_A;
      b_q  <= E_B;
      op_q <= E_MDOp;
    end
  end

  // Scheduler FSM: busy countdown, HI/LO commit and mthi/mtlo writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= (E_MDOp <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          end else if (E_MDOp == OP_MTHI) begin
            hi_q <= E_A;
          end else if (E_MDOp == OP_MTLO) begin
            lo_q <= E_A;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (!div_by_zero) begin
              hi_q <= res[63:32];
              lo_q <= res[31:0];
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The stall already covers the cycle a long op sits in E so a dependent
  // instruction cannot slip into E while the unit is starting.
  assign MDStall = D_MDUse & (busy_q | is_long_op);
  assign busy    = busy_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed test-plan steps followed by random traffic,
// every cycle compared against a behavioural model of the scheduler.
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  E_MDOp;
  logic [31:0] E_A, E_B;
  logic        D_MDUse;
  logic        busy;
  logic [31:0] HI, LO;
  logic        MDStall;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: remaining busy cycles and the result waiting to be committed.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [31:0] m_phi, m_plo;
  logic        m_pwr;
  int          stall_cnt = 0;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B),
    .D_MDUse(D_MDUse), .busy(busy), .HI(HI), .LO(LO), .MDStall(MDStall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference arithmetic: 64-bit integers, division via magnitudes and signs.
  task automatic calc(input int op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] h, output logic [31:0] l, output logic wr);
    longint sa, sb, p, ma, mb, q, r;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a) & 64'hFFFF_FFFF;
    ub = longint'(b) & 64'hFFFF_FFFF;
    wr = 1'b1;
    h = 32'd0;
    l = 32'd0;
    case (op)
      1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2: begin pu = ua * ub; h = pu[63:32]; l = pu[31:0]; end
      3: begin
        if (b == 0) wr = 1'b0;
        else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q = ma / mb;
          r = ma % mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          h = r[31:0];
          l = q[31:0];
        end
      end
      default: begin
        if (b == 0) wr = 1'b0;
        else begin
          h = 32'(ua % ub);
          l = 32'(ua / ub);
        end
      end
    endcase
  endtask

  // One clock: drive inputs, check the combinational stall, advance the model
  // across the rising edge, then check the registered outputs.
  task automatic step(input int op, input logic [31:0] a, input logic [31:0] b, input logic use_d);
    logic exp_stall;
    E_MDOp = 3'(op);
    E_A = a;
    E_B = b;
    D_MDUse = use_d;
    #1;
    exp_stall = use_d && ((m_left > 0) || (op >= 1 && op <= 4));
    check("stall", 32'(MDStall), 32'(exp_stall));
    if (MDStall) stall_cnt++;
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (op >= 1 && op <= 4) begin
      calc(op, a, b, m_phi, m_plo, m_pwr);
      m_left = (op <= 2) ? MULT_N : DIV_N;
    end else if (op == 5) begin
      m_hi = a;
    end else if (op == 6) begin
      m_lo = a;
    end
    #1;
    check("busy", 32'(busy), 32'(m_left > 0));
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    @(negedge clk);
  endtask

  task automatic idle_until_done();
    int guard = 0;
    while (m_left > 0 && guard < 40) begin
      step(0, 32'd0, 32'd0, 1'b0);
      guard++;
    end
    check("done_bound", 32'(m_left), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    E_MDOp = 3'd0;
    E_A = 32'd0;
    E_B = 32'd0;
    D_MDUse = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0;

    // mult -3 * 5
    step(1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    idle_until_done();
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFF1);

    // multu 0xFFFFFFFF * 2
    step(2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle_until_done();
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    // div -7 / 2 with the D-stage consumer waiting the whole time
    stall_cnt = 0;
    step(3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    for (int i = 0; i < DIV_N; i++) step(0, 32'd0, 32'd0, 1'b1);
    check("stall_cycles", 32'(stall_cnt), 32'(DIV_N + 1));
    step(0, 32'd0, 32'd0, 1'b1);
    check("stall_after", 32'(stall_cnt), 32'(DIV_N + 1));
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // divu 7 / 2, no consumer in D
    stall_cnt = 0;
    step(4, 32'd7, 32'd2, 1'b0);
    idle_until_done();
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);
    check("nouse_stall", 32'(stall_cnt), 32'd0);

    // divide by zero leaves HI/LO alone
    step(5, 32'h11, 32'd0, 1'b0);
    step(6, 32'h22, 32'd0, 1'b0);
    step(3, 32'h1234, 32'd0, 1'b0);
    idle_until_done();
    check("dz_hi", HI, 32'h11);
    check("dz_lo", LO, 32'h22);

    // new op in E while running must not disturb the original
    step(1, 32'd3, 32'd4, 1'b0);
    step(1, 32'd100, 32'd100, 1'b0);
    step(2, 32'd7, 32'd9, 1'b0);
    idle_until_done();
    check("ovr_lo", LO, 32'd12);
    check("ovr_hi", HI, 32'd0);

    // asynchronous reset in the third busy cycle
    step(1, 32'h1000, 32'h1000, 1'b0);
    step(0, 32'd0, 32'd0, 1'b0);
    step(0, 32'd0, 32'd0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    m_left = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    step(0, 32'd0, 32'd0, 1'b0);

    // random traffic, including ops arriving while running
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] a, b;
      op = int'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 9));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      step(op, a, b, 1'($urandom_range(0, 1)));
    end
    idle_until_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
